// File: rtl/lmx2594_cfg_seq.sv
// LMX2594 configuration sequencer: power-up wait, init-table streaming through spi_master,
// VCO calibration wait, then single-word runtime writes from the host port.
module lmx2594_cfg_seq #(
   parameter int unsigned PWRUP_CYCLES    = 30000,
   parameter int unsigned NUM_REGS        = 8,
   parameter int unsigned GAP_CYCLES      = 16,
   parameter int unsigned CAL_WAIT_CYCLES = 1000,
   parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   output logic [7:0]  tbl_addr,
   input  logic [23:0] tbl_data,
   input  logic        req_valid,
   input  logic [23:0] req_data,
   output logic        req_ready,
   output logic        spi_start,
   output logic        spi_dir,
   output logic [7:0]  spi_data_depth,
   output logic [23:0] spi_data_tx,
   input  logic        spi_ready,
   output logic        amp_en,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned WORD_W = 24;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [3:0] {
      S_PWRUP     = 4'd0,
      S_FETCH     = 4'd1,
      S_LOAD      = 4'd2,
      S_START     = 4'd3,
      S_WAIT_BUSY = 4'd4,
      S_WAIT_DONE = 4'd5,
      S_GAP       = 4'd6,
      S_CAL_WAIT  = 4'd7,
      S_READY     = 4'd8,
      S_ERROR     = 4'd9
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                host_q, host_d;
   logic [WORD_W-1:0]   data_d;
   logic                done_d, err_d, start_d;
   logic                req_ready_q;
   logic                pwrup_end, gap_end, cal_end, wd_expired, last_idx;

   // Shared cycle counter restarts on every state change; terminal counts per state.
   assign pwrup_end  = (cnt_q == CNT_W'(PWRUP_CYCLES - 1));
   assign gap_end    = (cnt_q == CNT_W'(GAP_CYCLES - 1));
   assign cal_end    = (cnt_q == CNT_W'(CAL_WAIT_CYCLES - 1));
   assign wd_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign last_idx   = (idx_q == IDX_W'(NUM_REGS - 1));

   assign tbl_addr       = idx_q;
   assign spi_dir        = 1'b0;
   assign spi_data_depth = IDX_W'(WORD_W);

   // A concurrent cfg_start withdraws the offer so the host never sees a dropped accept.
   assign req_ready = req_ready_q & ~cfg_start;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      host_d  = host_q;
      data_d  = spi_data_tx;
      done_d  = cfg_done;
      err_d   = cfg_err;
      start_d = 1'b0;

      unique case (state_q)
         S_PWRUP: begin
            if (pwrup_end) begin
               idx_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            data_d  = tbl_data;
            state_d = S_START;
         end
         S_START: begin
            if (spi_ready) begin
               start_d = 1'b1;
               state_d = S_WAIT_BUSY;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_WAIT_BUSY: begin
            if (!spi_ready) begin
               state_d = S_WAIT_DONE;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_WAIT_DONE: begin
            if (spi_ready) begin
               state_d = S_GAP;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_GAP: begin
            if (gap_end) begin
               if (host_q) begin
                  state_d = S_READY;
               end else if (last_idx) begin
                  state_d = S_CAL_WAIT;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_CAL_WAIT: begin
            if (cal_end) begin
               done_d  = 1'b1;
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (cfg_start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               idx_d   = '0;
               host_d  = 1'b0;
               state_d = S_FETCH;
            end else if (req_valid) begin
               data_d  = req_data;
               host_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_ERROR: begin
            if (cfg_start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               idx_d   = '0;
               host_d  = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_PWRUP;
      endcase

      cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_PWRUP;
         cnt_q       <= '0;
         idx_q       <= '0;
         host_q      <= 1'b0;
         spi_data_tx <= '0;
         spi_start   <= 1'b0;
         req_ready_q <= 1'b0;
         amp_en      <= 1'b0;
         cfg_busy    <= 1'b1;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         host_q      <= host_d;
         spi_data_tx <= data_d;
         spi_start   <= start_d;
         req_ready_q <= (state_d == S_READY);
         // The amplifier stays on across a host write; only init, reset or error turn it off.
         amp_en      <= (state_d == S_READY) || (host_d && (state_d != S_ERROR));
         cfg_busy    <= (state_d != S_READY) && (state_d != S_ERROR);
         cfg_done    <= done_d;
         cfg_err     <= err_d;
      end
   end

endmodule

// File: tb/tb_lmx2594_cfg_seq.sv
// Bench for lmx2594_cfg_seq: behavioural spi_master and ROM, scoreboard of expected SPI words,
// directed scenarios for init, host writes, start/request collision, watchdog, reset and back-pressure.
module tb_lmx2594_cfg_seq;

   localparam int P   = 20;
   localparam int N   = 3;
   localparam int G   = 4;
   localparam int CAL = 10;
   localparam int T   = 50;

   localparam logic [23:0] W0 = 24'h700000;
   localparam logic [23:0] W1 = 24'h2C0000;
   localparam logic [23:0] W2 = 24'h00241C;
   localparam logic [23:0] HW = 24'h4E0087;
   localparam logic [23:0] BW = 24'h240005;

   localparam int SEL_START = 0;
   localparam int SEL_READY = 1;
   localparam int SEL_DONE  = 2;
   localparam int SEL_ERR   = 3;
   localparam int SEL_RREQ  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic        req_valid = 1'b0;
   logic [23:0] req_data = '0;
   logic [23:0] tbl_data;
   logic [7:0]  tbl_addr, spi_data_depth;
   logic [23:0] spi_data_tx;
   logic        req_ready, spi_start, spi_dir, spi_ready;
   logic        amp_en, cfg_busy, cfg_done, cfg_err;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int n_starts = 0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_w;

   logic model_ready = 1'b1;
   logic hang = 1'b0;
   logic bp = 1'b0;
   int   mc = 0;

   lmx2594_cfg_seq #(
      .PWRUP_CYCLES(P), .NUM_REGS(N), .GAP_CYCLES(G),
      .CAL_WAIT_CYCLES(CAL), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .spi_start(spi_start), .spi_dir(spi_dir), .spi_data_depth(spi_data_depth),
      .spi_data_tx(spi_data_tx), .spi_ready(spi_ready),
      .amp_en(amp_en), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Registered init ROM.
   always @(posedge clk) begin
      case (tbl_addr)
         8'd0:    tbl_data <= W0;
         8'd1:    tbl_data <= W1;
         8'd2:    tbl_data <= W2;
         default: tbl_data <= '0;
      endcase
   end

   // spi_master model: ready drops 2 cycles after the pulse and stays low 30 cycles.
   always @(posedge clk) begin
      if (mc == 0) begin
         if (spi_start && !hang) mc <= 1;
      end else begin
         if (mc == 1) model_ready <= 1'b0;
         if (mc == 31) begin
            model_ready <= 1'b1;
            mc <= 0;
         end else begin
            mc <= mc + 1;
         end
      end
   end
   assign spi_ready = model_ready & ~bp;

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   function automatic void chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endfunction

   function automatic logic cur(input int sel);
      case (sel)
         SEL_START: return spi_start;
         SEL_READY: return spi_ready;
         SEL_DONE:  return cfg_done;
         SEL_ERR:   return cfg_err;
         default:   return req_ready;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         SEL_START: return "spi_start";
         SEL_READY: return "spi_ready";
         SEL_DONE:  return "cfg_done";
         SEL_ERR:   return "cfg_err";
         default:   return "req_ready";
      endcase
   endfunction

   // Waits (bounded) until a signal takes a value; stamp is the cycle count when seen.
   task automatic wait_for(input int sel, input logic val, input int budget, output int stamp);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (cur(sel) === val) hit = 1'b1;
      end
      stamp = cycle;
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_%s: not %0b within %0d cycles", sel_name(sel), val, budget);
      end
   endtask

   // Remaining init words, then calibration wait into READY.
   task automatic wait_init(input int nstarts);
      int t, tr, td;
      for (int i = 0; i < nstarts; i++) begin
         wait_for(SEL_START, 1'b1, 400, t);
         chk("done_low_during_init", 32'(cfg_done), 0);
      end
      wait_for(SEL_READY, 1'b0, 100, t);
      wait_for(SEL_READY, 1'b1, 100, tr);
      chk("amp_off_before_done", 32'(amp_en), 0);
      wait_for(SEL_DONE, 1'b1, 100, td);
      chk_range("init_done_delay", td - tr, G + CAL, G + CAL + 1);
      chk("amp_en_with_done", 32'(amp_en), 1);
      chk("req_ready_with_done", 32'(req_ready), 1);
      chk("busy_low_in_ready", 32'(cfg_busy), 0);
   endtask

   // Scoreboard monitor: every start pulse must carry the next expected word.
   always @(negedge clk) begin
      if (spi_start === 1'b1) begin
         n_starts++;
         chk("ready_at_start", 32'(spi_ready), 1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_start: word 0x%06h, required none", spi_data_tx);
         end else begin
            mon_w = exp_q.pop_front();
            if (spi_data_tx !== mon_w) begin
               errors++;
               $display("FAIL spi_data_tx: got 0x%06h, required 0x%06h", spi_data_tx, mon_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int t0, t, tr, tq, ns;
      bit amp_ok, seen_low;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tbl_addr", 32'(tbl_addr), 0);
      chk("rst_spi_data_tx", 32'(spi_data_tx), 0);
      chk("rst_spi_start", 32'(spi_start), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_amp_en", 32'(amp_en), 0);
      chk("rst_cfg_busy", 32'(cfg_busy), 1);
      chk("rst_cfg_done", 32'(cfg_done), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_spi_dir", 32'(spi_dir), 0);
      chk("rst_spi_depth", 32'(spi_data_depth), 24);

      // Power-up init.
      @(posedge clk); #1;
      t0 = cycle;
      rst = 1'b0;
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      wait_for(SEL_START, 1'b1, 100, t);
      chk("pwrup_first_start", t - t0, P + 3);
      chk("amp_off_pwrup", 32'(amp_en), 0);
      wait_init(2);

      // Host write.
      @(posedge clk); #1;
      t0 = cycle;
      req_valid = 1'b1;
      req_data  = HW;
      exp_q.push_back(HW);
      @(negedge clk);
      chk("host_req_offer", 32'(req_ready), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_data  = '0;
      @(negedge clk);
      chk("host_req_ready_drop", 32'(req_ready), 0);
      wait_for(SEL_START, 1'b1, 50, t);
      chk("host_start_latency", t - t0, 2);
      amp_ok = 1'b1;
      seen_low = 1'b0;
      tr = -1000;
      tq = -1;
      for (int i = 0; i < 200 && tq < 0; i++) begin
         @(negedge clk);
         if (amp_en !== 1'b1) amp_ok = 1'b0;
         if (spi_ready === 1'b0) seen_low = 1'b1;
         else if (seen_low && tr < 0) tr = cycle;
         if (req_ready === 1'b1) tq = cycle;
      end
      chk("host_amp_en_held", 32'(amp_ok), 1);
      chk_range("host_req_ready_return", tq - tr, G, G + 1);
      chk("host_done_kept", 32'(cfg_done), 1);

      // cfg_start and req_valid together: request refused, table replayed without power-up wait.
      @(posedge clk); #1;
      t0 = cycle;
      cfg_start = 1'b1;
      req_valid = 1'b1;
      req_data  = HW;
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      @(negedge clk);
      chk("collide_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      @(negedge clk);
      chk("collide_done_cleared", 32'(cfg_done), 0);
      wait_for(SEL_START, 1'b1, 100, t);
      chk("replay_first_start", t - t0, 4);
      wait_init(2);

      // Watchdog: second transaction never goes busy.
      @(posedge clk); #1;
      cfg_start = 1'b1;
      exp_q.push_back(W0); exp_q.push_back(W1);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      wait_for(SEL_START, 1'b1, 100, t);
      @(posedge clk); #1;
      hang = 1'b1;
      wait_for(SEL_START, 1'b1, 200, t);
      wait_for(SEL_ERR, 1'b1, 200, tq);
      chk("timeout_delay", tq - t, T);
      chk("error_amp_en", 32'(amp_en), 0);
      chk("error_busy", 32'(cfg_busy), 0);
      chk("error_req_ready", 32'(req_ready), 0);
      chk("error_done", 32'(cfg_done), 0);
      ns = n_starts;
      repeat (60) @(negedge clk);
      @(posedge clk);
      chk("error_no_starts", n_starts, ns);
      chk("error_sticky", 32'(cfg_err), 1);
      #1;
      hang = 1'b0;
      cfg_start = 1'b1;
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("error_cleared", 32'(cfg_err), 0);
      wait_init(3);

      // Reset during the second word's transfer.
      @(posedge clk); #1;
      cfg_start = 1'b1;
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      wait_for(SEL_START, 1'b1, 100, t);
      wait_for(SEL_START, 1'b1, 100, t);
      wait_for(SEL_READY, 1'b0, 50, t);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      t0 = cycle;
      rst = 1'b0;
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      @(negedge clk);
      chk("midrst_amp_en", 32'(amp_en), 0);
      chk("midrst_done", 32'(cfg_done), 0);
      chk("midrst_tbl_addr", 32'(tbl_addr), 0);
      chk("midrst_busy", 32'(cfg_busy), 1);
      wait_for(SEL_START, 1'b1, 100, t);
      chk("midrst_first_start", t - t0, P + 3);
      wait_init(2);

      // Back-pressure: spi_ready held low for 10 cycles as START is entered.
      @(posedge clk); #1;
      t0 = cycle;
      req_valid = 1'b1;
      req_data  = BW;
      bp = 1'b1;
      exp_q.push_back(BW);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_data  = '0;
      repeat (9) @(posedge clk);
      #1;
      bp = 1'b0;
      wait_for(SEL_START, 1'b1, 100, t);
      chk("bp_start_latency", t - t0, 11);
      chk("bp_no_error", 32'(cfg_err), 0);
      chk("bp_amp_en", 32'(amp_en), 1);
      wait_for(SEL_READY, 1'b0, 50, t);
      wait_for(SEL_RREQ, 1'b1, 100, t);
      chk("bp_no_error_end", 32'(cfg_err), 0);

      @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("total_starts", n_starts, 3 + 1 + 3 + 5 + 5 + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
